// File: rtl/oc8051_pt_loader_if.sv
//==============================================================================
// oc8051_pt_loader_if : privileged XRAM stb/ack bus used by the page-table loader
// Revision 1.0
//==============================================================================
`default_nettype none

interface oc8051_pt_loader_if;
  logic [15:0] xram_addr;
  logic [7:0]  xram_data_out;
  logic [7:0]  xram_data_in;
  logic        xram_wr;
  logic        xram_stb;
  logic        xram_ack;
  logic        priv_lvl;
  logic [2:0]  accesser;

  modport master (
    output xram_addr, xram_data_out, xram_wr, xram_stb, priv_lvl, accesser,
    input  xram_data_in, xram_ack
  );

  modport slave (
    input  xram_addr, xram_data_out, xram_wr, xram_stb, priv_lvl, accesser,
    output xram_data_in, xram_ack
  );
endinterface

`default_nettype wire

// File: rtl/oc8051_pt_loader.sv
//==============================================================================
// oc8051_pt_loader : secure-boot copier of a 64-byte policy image into the page table
// Option macro OC8051_PT_LOADER_VERIFY_EN adds a readback compare of every write.
// Revision 1.0
//==============================================================================
`default_nettype none

module oc8051_pt_loader #(
  parameter logic [15:0] PT_BASE     = 16'hFF80,
  parameter int          IMG_BYTES   = 64,
  parameter int          ACK_TIMEOUT = 15,
  parameter bit          LOCK        = 1'b1
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              start,
  input  wire logic [15:0]       src_base,
  oc8051_pt_loader_if.master     bus,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             err_code,
  output logic [15:0]            err_addr
);

  localparam logic [5:0]  c_LAST_IDX  = 6'(IMG_BYTES - 1);
  localparam logic [16:0] c_SPAN      = 17'(IMG_BYTES - 1);
  localparam logic [3:0]  c_WAIT_LAST = 4'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_RD_SRC = 3'd2,
    S_WR_PT  = 3'd3,
`ifdef OC8051_PT_LOADER_VERIFY_EN
    S_RB_PT  = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t      r_state;
  logic [5:0]  r_idx;
  logic [7:0]  r_byte;
  logic [15:0] r_src;
  logic [3:0]  r_wcnt;
  logic        r_fin;

  logic [16:0] w_end;
  logic        w_bad;
  logic        w_bus_state;

  // Last source byte computed in 17 bits so a carry flags wrap-around.
  assign w_end = {1'b0, r_src} + c_SPAN;
  assign w_bad = w_end[16] || (w_end[15:0] >= PT_BASE);

`ifdef OC8051_PT_LOADER_VERIFY_EN
  assign w_bus_state = (r_state == S_RD_SRC) || (r_state == S_WR_PT) || (r_state == S_RB_PT);
`else
  assign w_bus_state = (r_state == S_RD_SRC) || (r_state == S_WR_PT);
`endif

  assign bus.priv_lvl = bus.xram_stb;
  assign bus.accesser = 3'b001;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= S_IDLE;
      r_idx             <= 6'd0;
      r_byte            <= 8'd0;
      r_src             <= 16'd0;
      r_wcnt            <= 4'd0;
      r_fin             <= 1'b0;
      bus.xram_addr     <= 16'd0;
      bus.xram_data_out <= 8'd0;
      bus.xram_wr       <= 1'b0;
      bus.xram_stb      <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      err_code          <= 2'b00;
      err_addr          <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !(LOCK && done)) begin
            r_src   <= src_base;
            done    <= 1'b0;
            error   <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (w_bad) begin
            error    <= 1'b1;
            busy     <= 1'b0;
            err_code <= 2'b11;
            err_addr <= r_src;
            r_state  <= S_ERR;
          end else begin
            r_idx         <= 6'd0;
            r_fin         <= 1'b0;
            r_wcnt        <= 4'd0;
            bus.xram_addr <= r_src;
            bus.xram_wr   <= 1'b0;
            bus.xram_stb  <= 1'b1;
            r_state       <= S_RD_SRC;
          end
        end

        S_DONE, S_ERR: r_state <= S_IDLE;

        default: begin
          if (!w_bus_state) begin
            r_state <= S_IDLE;
          end else if (!bus.xram_stb) begin
            // One idle bus cycle after every ack; the last one hands over to DONE.
            if (r_fin) begin
              r_fin   <= 1'b0;
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_DONE;
            end else begin
              bus.xram_stb <= 1'b1;
              r_wcnt       <= 4'd0;
            end
          end else if (bus.xram_ack) begin
            bus.xram_stb <= 1'b0;
            if (r_state == S_RD_SRC) begin
              r_byte            <= bus.xram_data_in;
              bus.xram_data_out <= bus.xram_data_in;
              bus.xram_addr     <= PT_BASE + {10'd0, r_idx};
              bus.xram_wr       <= 1'b1;
              r_state           <= S_WR_PT;
`ifdef OC8051_PT_LOADER_VERIFY_EN
            end else if (r_state == S_WR_PT) begin
              bus.xram_wr <= 1'b0;
              r_state     <= S_RB_PT;
            end else if (bus.xram_data_in != r_byte) begin
              error    <= 1'b1;
              busy     <= 1'b0;
              err_code <= 2'b10;
              err_addr <= bus.xram_addr;
              r_state  <= S_ERR;
`endif
            end else if (r_idx == c_LAST_IDX) begin
              r_fin <= 1'b1;
            end else begin
              r_idx         <= r_idx + 6'd1;
              bus.xram_addr <= r_src + {10'd0, r_idx + 6'd1};
              bus.xram_wr   <= 1'b0;
              r_state       <= S_RD_SRC;
            end
          end else if (r_wcnt == c_WAIT_LAST) begin
            bus.xram_stb <= 1'b0;
            error        <= 1'b1;
            busy         <= 1'b0;
            err_code     <= 2'b01;
            err_addr     <= bus.xram_addr;
            r_state      <= S_ERR;
          end else begin
            r_wcnt <= r_wcnt + 4'd1;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_oc8051_pt_loader.sv
//==============================================================================
// tb_oc8051_pt_loader : directed + randomized bench with an XRAM responder model
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_oc8051_pt_loader;

`ifdef OC8051_PT_LOADER_VERIFY_EN
  localparam int XACT = 3;
`else
  localparam int XACT = 2;
`endif
  localparam int LOAD_CYC = 1 + 64 * 2 * XACT;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] src_base;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [15:0] err_addr;

  always #5 clk = ~clk;

  oc8051_pt_loader_if bus ();

  oc8051_pt_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_base (src_base),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_code (err_code),
    .err_addr (err_addr)
  );

  // XRAM model: source memory below the window, page-table bytes above it.
  logic [7:0]  src_mem [0:65535];
  logic [7:0]  pt_mem  [0:127];
  logic        clr_pt = 1'b0, rand_dly = 1'b0, hold_on = 1'b0, corrupt_on = 1'b0;
  logic [15:0] hold_addr = 16'hFF85, corrupt_addr = 16'hFFA3;
  logic [15:0] lim_pt = 16'hFFFF, lim_src = 16'hFFFF;
  int unsigned wcnt = 0, cur_dly = 0;
  logic [7:0]  rd_byte;

  assign bus.xram_ack = bus.xram_stb && (wcnt >= cur_dly) &&
                        !(hold_on && bus.xram_addr == hold_addr);

  always_comb begin
    rd_byte = (bus.xram_addr >= 16'hFF80) ? pt_mem[bus.xram_addr[6:0]] : src_mem[bus.xram_addr];
    if (corrupt_on && !bus.xram_wr && bus.xram_addr == corrupt_addr) rd_byte = ~rd_byte;
    bus.xram_data_in = rd_byte;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt    <= 0;
      cur_dly <= 0;
    end else if (clr_pt) begin
      for (int i = 0; i < 128; i++) pt_mem[i] <= 8'h00;
    end else if (bus.xram_stb) begin
      if (bus.xram_ack) begin
        wcnt    <= 0;
        cur_dly <= rand_dly ? $urandom_range(0, 5) : 0;
        if (bus.xram_wr && bus.xram_addr >= 16'hFF80) pt_mem[bus.xram_addr[6:0]] <= bus.xram_data_out;
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // Bus monitor counters; the directed sequence reads deltas of these.
  int          priv_bad = 0, stab_bad = 0, stb_cyc = 0, hold_cyc = 0, wr_cnt = 0, past_cnt = 0;
  logic        p_stb = 1'b0;
  logic [24:0] p_bus = '0;

  always @(negedge clk) begin
    if (bus.priv_lvl !== bus.xram_stb) priv_bad <= priv_bad + 1;
    if (bus.xram_stb && p_stb && {bus.xram_addr, bus.xram_wr, bus.xram_data_out} !== p_bus)
      stab_bad <= stab_bad + 1;
    if (bus.xram_stb) stb_cyc <= stb_cyc + 1;
    if (bus.xram_stb && bus.xram_addr == hold_addr) hold_cyc <= hold_cyc + 1;
    if (bus.xram_stb && bus.xram_ack && bus.xram_wr) wr_cnt <= wr_cnt + 1;
    if (bus.xram_stb && ((bus.xram_addr >= 16'hFF80 && bus.xram_addr > lim_pt) ||
                         (bus.xram_addr <  16'hFF80 && bus.xram_addr > lim_src)))
      past_cnt <= past_cnt + 1;
    p_stb <= bus.xram_stb;
    p_bus <= {bus.xram_addr, bus.xram_wr, bus.xram_data_out};
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] s);
    src_base = s;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_end(input int max, output int n);
    n = 0;
    while (!(done || error) && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic clear_pt;
    clr_pt = 1'b1;
    tick();
    clr_pt = 1'b0;
  endtask

  // Reference rule for an unusable source window.
  function automatic bit src_is_bad(input int s);
    return (s + 63 > 65535) || (s + 63 >= 'hFF80);
  endfunction

  initial begin
    int          n, s0, s1, s2, s3, k;
    logic [15:0] src, src2;
    logic [7:0]  exp_img [0:63];
    logic [15:0] bad_src [0:1];

    rst = 1'b0; start = 1'b0; src_base = 16'h0000;
    for (int i = 0; i < 65536; i++) src_mem[i] = 8'($urandom);
    for (int i = 0; i < 64; i++) src_mem[16'h1000 + i] = 8'(i) ^ 8'hA5;
    repeat (3) tick();

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_code", err_code, 0);
    chk("rst_eaddr", err_addr, 0);
    chk("rst_stb", bus.xram_stb, 0);
    chk("rst_addr", bus.xram_addr, 0);
    chk("rst_wr", bus.xram_wr, 0);
    chk("rst_dout", bus.xram_data_out, 0);
    chk("rst_priv", bus.priv_lvl, 0);
    chk("rst_accesser", bus.accesser, 3'b001);
    rst = 1'b1;
    tick();
    clear_pt();

    // Overlapping and wrapping source windows
    bad_src[0] = 16'hFF60;
    bad_src[1] = 16'hFFF0;
    for (int b = 0; b < 2; b++) begin
      s0 = stb_cyc;
      pulse_start(bad_src[b]);
      wait_end(20, n);
      chk("bad_model", 32'(src_is_bad(int'(bad_src[b]))), 1);
      chk("bad_lat", n, 1);
      chk("bad_error", error, 1);
      chk("bad_code", err_code, 2'b11);
      chk("bad_eaddr", err_addr, bad_src[b]);
      chk("bad_busy", busy, 0);
      tick();
      chk("bad_nostb", stb_cyc - s0, 0);
    end

    // Nominal zero-wait load
    s0 = priv_bad; s1 = wr_cnt; s2 = stab_bad;
    pulse_start(16'h1000);
    chk("ld_busy", busy, 1);
    wait_end(1000, n);
    chk("ld_cycles", n, LOAD_CYC);
    chk("ld_done", done, 1);
    chk("ld_error", error, 0);
    chk("ld_busy_end", busy, 0);
    tick();
    chk("ld_wrcnt", wr_cnt - s1, 64);
    chk("ld_priv", priv_bad - s0, 0);
    chk("ld_stab", stab_bad - s2, 0);
    chk("ld_sticky", done, 1);
    for (int i = 0; i < 64; i++) chk($sformatf("ld_pt%0d", i), pt_mem[i], 8'(i) ^ 8'hA5);

    // Missing ack on a page-table write
    do_reset();
    clear_pt();
    hold_on = 1'b1; hold_addr = 16'hFF85;
    s0 = hold_cyc;
    pulse_start(16'h1000);
    wait_end(2000, n);
    chk("to_error", error, 1);
    chk("to_done", done, 0);
    chk("to_code", err_code, 2'b01);
    chk("to_eaddr", err_addr, 16'hFF85);
    chk("to_busy", busy, 0);
    tick();
    chk("to_stbcyc", hold_cyc - s0, 15);
    chk("to_pt4", pt_mem[4], 8'd4 ^ 8'hA5);
    chk("to_pt5", pt_mem[5], 8'h00);
    s1 = stb_cyc;
    repeat (20) tick();
    chk("to_nostb", stb_cyc - s1, 0);
    hold_on = 1'b0;

`ifdef OC8051_PT_LOADER_VERIFY_EN
    // Corrupted readback
    clear_pt();
    corrupt_on = 1'b1; corrupt_addr = 16'hFFA3;
    lim_pt = 16'hFFA3; lim_src = 16'h1000 + 16'd35;
    s0 = past_cnt;
    pulse_start(16'h1000);
    wait_end(2000, n);
    chk("vf_error", error, 1);
    chk("vf_code", err_code, 2'b10);
    chk("vf_eaddr", err_addr, 16'hFFA3);
    chk("vf_busy", busy, 0);
    repeat (5) tick();
    chk("vf_past", past_cnt - s0, 0);
    corrupt_on = 1'b0; lim_pt = 16'hFFFF; lim_src = 16'hFFFF;
`endif

    // Reset in the middle of a load, then the lock
    do_reset();
    clear_pt();
    pulse_start(16'h1000);
    k = 0;
    while (!(bus.xram_stb && bus.xram_addr == 16'h1014) && k < 500) begin
      tick();
      k++;
    end
    chk("ab_reach", 32'(k < 500), 1);
    #2 rst = 1'b0;
    #1;
    chk("ab_stb", bus.xram_stb, 0);
    chk("ab_done", done, 0);
    chk("ab_error", error, 0);
    chk("ab_busy", busy, 0);
    tick();
    rst = 1'b1;
    s0 = stb_cyc;
    repeat (10) tick();
    chk("ab_quiet", stb_cyc - s0, 0);
    chk("ab_pt19", pt_mem[19], 8'd19 ^ 8'hA5);
    chk("ab_pt20", pt_mem[20], 8'h00);
    pulse_start(16'h1000);
    wait_end(1000, n);
    chk("lk_first", done, 1);
    tick();
    s0 = stb_cyc;
    pulse_start(16'h2000);
    repeat (20) tick();
    chk("lk_nostb", stb_cyc - s0, 0);
    chk("lk_done", done, 1);
    chk("lk_busy", busy, 0);

    // Random ack latency with start pulses during the load
    do_reset();
    clear_pt();
    rand_dly = 1'b1;
    src  = 16'($urandom_range(0, 16'hFE00));
    src2 = 16'($urandom_range(0, 16'hFE00));
    for (int i = 0; i < 64; i++) exp_img[i] = src_mem[src + 16'(i)];
    s0 = stab_bad; s1 = priv_bad; s2 = wr_cnt; s3 = 0;
    pulse_start(src);
    for (int p = 0; p < 5; p++) begin
      repeat (37) tick();
      if (busy !== 1'b1) s3++;
      pulse_start(src2);
    end
    chk("rn_busy_mid", s3, 0);
    wait_end(5000, n);
    chk("rn_done", done, 1);
    chk("rn_error", error, 0);
    tick();
    chk("rn_wrcnt", wr_cnt - s2, 64);
    chk("rn_stab", stab_bad - s0, 0);
    chk("rn_priv", priv_bad - s1, 0);
    for (int i = 0; i < 64; i++) chk($sformatf("rn_pt%0d", i), pt_mem[i], exp_img[i]);
    rand_dly = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
